// File: rtl/banked_ram_pkg.sv
// banked_ram_pkg: default window addresses, open-bus value and bank-register helper
package banked_ram_pkg;
  localparam int WRAM_BASE_DEF = 'hC000;
  localparam int ECHO_BASE_DEF = 'hE000;
  localparam int SVBK_DEF = 'hFF70;
  localparam int ECHO_SPAN = 'h1E00;
  localparam logic [7:0] OPEN_BUS = 8'hFF;
  function automatic logic [2:0] bank_val(input logic [7:0] d);
    return (d[2:0] == 3'd0) ? 3'd1 : d[2:0];
  endfunction
endpackage

// File: rtl/banked_ram_array.sv
// ram_array: single-port byte array, combinational read and rising-edge write on one address
//   clk_i clock, we_i write strobe, addr_i shared read/write address,
//   wdata_i write byte, rdata_o byte at addr_i
module ram_array #(
  parameter int AW = 15
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [2**AW];
  always_ff @(posedge clk_i) if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/banked_ram.sv
// banked_ram: banked work RAM with echo window, bank register and a one-byte-per-cycle DMA read port
//   clk/reset clock and async active-high reset; abs_addr/data_w/write_enable CPU access,
//   data_r CPU read data (falling edge), sel window hit; dma_req/dma_addr DMA request,
//   dma_data/dma_valid DMA response one cycle later
module banked_ram
  import banked_ram_pkg::*;
#(
  parameter int BASE      = WRAM_BASE_DEF,
  parameter int BANK_SIZE = 'h1000,
  parameter int BANK_BITS = 12,
  parameter int NUM_BANKS = 8,
  parameter int ECHO      = 1,
  parameter int ECHO_BASE = ECHO_BASE_DEF,
  parameter int BANKREG   = SVBK_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] abs_addr,
  input  logic [7:0]  data_w,
  input  logic        write_enable,
  output logic [7:0]  data_r,
  output logic        sel,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  output logic [7:0]  dma_data,
  output logic        dma_valid
);
  localparam int NB = $clog2(NUM_BANKS);
  localparam int AW = BANK_BITS + NB;
  function automatic logic ram_hit(input logic [15:0] a);
    return 32'(a) >= BASE && 32'(a) < BASE + 2 * BANK_SIZE;
  endfunction
  function automatic logic echo_hit(input logic [15:0] a);
    return ECHO != 0 && 32'(a) >= ECHO_BASE && 32'(a) < ECHO_BASE + ECHO_SPAN;
  endfunction
  // echo addresses are rebased onto the RAM window before splitting region and offset
  function automatic logic [AW-1:0] phys(input logic [15:0] a, input logic [2:0] bank);
    logic [31:0] off;
    off = 32'(a) - 32'(echo_hit(a) ? ECHO_BASE : BASE);
    return {off[BANK_BITS] ? bank[NB-1:0] : NB'(0), off[BANK_BITS-1:0]};
  endfunction
  logic [2:0] bank_q, bank_d;
  logic cpu_mem, cpu_reg, dma_hit, we;
  logic [AW-1:0] addr;
  logic [7:0] rdata;
  assign cpu_reg = 32'(abs_addr) == BANKREG;
  assign cpu_mem = ram_hit(abs_addr) || echo_hit(abs_addr);
  assign dma_hit = ram_hit(dma_addr) || echo_hit(dma_addr);
  assign sel = cpu_mem || cpu_reg;
  // the single storage port belongs to DMA whenever dma_req is high
  assign addr = dma_req ? phys(dma_addr, bank_q) : phys(abs_addr, bank_q);
  assign we = write_enable && cpu_mem && !dma_req;
  assign bank_d = (write_enable && cpu_reg) ? bank_val(data_w) : bank_q;
  ram_array #(.AW(AW)) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (data_w),
    .rdata_o (rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bank_q    <= 3'd1;
      dma_data  <= OPEN_BUS;
      dma_valid <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      dma_valid <= dma_req;
      dma_data  <= dma_req ? (dma_hit ? rdata : OPEN_BUS) : dma_data;
    end
  always_ff @(negedge clk or posedge reset)
    if (reset) data_r <= OPEN_BUS;
    else if (sel) data_r <= cpu_reg ? {5'b11111, bank_q} : (dma_req ? OPEN_BUS : rdata);
endmodule

// File: tb/tb_banked_ram.sv
// tb_banked_ram: directed scoreboard bench for banked_ram
module tb_banked_ram;
  logic clk = 1'b0, reset = 1'b0;
  logic [15:0] abs_addr = '0, dma_addr = '0;
  logic [7:0] data_w = '0;
  logic write_enable = 1'b0, dma_req = 1'b0;
  logic [7:0] data_r, dma_data, ne_data_r, ne_dma_data;
  logic sel, dma_valid, ne_sel, ne_dma_valid;
  int chk = 0, err = 0, pulses = 0;
  logic [7:0] q[$];
  logic [7:0] rd;
  logic sel_s, ne_sel_s;
  banked_ram u_dut (
    .clk(clk), .reset(reset), .abs_addr(abs_addr), .data_w(data_w), .write_enable(write_enable),
    .data_r(data_r), .sel(sel), .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_data(dma_data), .dma_valid(dma_valid)
  );
  banked_ram #(.ECHO(0)) u_ne (
    .clk(clk), .reset(reset), .abs_addr(abs_addr), .data_w(data_w), .write_enable(write_enable),
    .data_r(ne_data_r), .sel(ne_sel), .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_data(ne_dma_data), .dma_valid(ne_dma_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] pat(input int i);
    return 8'(i * 13 + 7);
  endfunction
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic [15:0] a, input logic [7:0] wd, input logic we,
                     input logic dr, input logic [15:0] da);
    abs_addr = a; data_w = wd; write_enable = we; dma_req = dr; dma_addr = da;
    @(negedge clk); #1;
    rd = data_r; sel_s = sel; ne_sel_s = ne_sel;
    @(posedge clk); #1;
    check("dma_valid", 16'(dma_valid), 16'(dr));
    if (dma_valid) begin
      pulses++;
      check("dma_queue_nonempty", 16'(q.size() != 0), 16'd1);
      if (q.size() != 0) check("dma_data", 16'(dma_data), 16'(q.pop_front()));
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(a, d, 1'b1, 1'b0, 16'h0);
  endtask
  task automatic rdchk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    cyc(a, 8'h00, 1'b0, 1'b0, 16'h0);
    check(tag, 16'(rd), 16'(exp));
  endtask
  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset_data_r", 16'(data_r), 16'h00FF);
    check("reset_dma_data", 16'(dma_data), 16'h00FF);
    check("reset_dma_valid", 16'(dma_valid), 16'h0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    rdchk("bankreg_reset", 16'hFF70, 8'hF9);
    check("sel_bankreg", 16'(sel_s), 16'd1);
    wr(16'hD000, 8'h5A);
    rdchk("bank1_d000", 16'hD000, 8'h5A);
    wr(16'hD123, 8'h42);
    wr(16'hFF70, 8'h05);
    rdchk("bankreg_5", 16'hFF70, 8'hFD);
    wr(16'hD123, 8'hA5);
    wr(16'hFF70, 8'h00);
    rdchk("bankreg_0_is_1", 16'hFF70, 8'hF9);
    rdchk("bank1_d123", 16'hD123, 8'h42);
    wr(16'hFF70, 8'h05);
    rdchk("bank5_d123", 16'hD123, 8'hA5);
    wr(16'hC010, 8'h3C);
    rdchk("echo_read", 16'hE010, 8'h3C);
    check("echo_sel", 16'(sel_s), 16'd1);
    check("noecho_sel", 16'(ne_sel_s), 16'd0);
    wr(16'hF010, 8'h77);
    rdchk("echo_write", 16'hD010, 8'h77);
    cyc(16'hB010, 8'h00, 1'b0, 1'b0, 16'h0);
    check("miss_sel", 16'(sel_s), 16'd0);
    check("miss_hold", 16'(rd), 16'h0077);
    wr(16'hDDFF, 8'h61);
    rdchk("echo_top", 16'hFDFF, 8'h61);
    cyc(16'hFE00, 8'h00, 1'b0, 1'b0, 16'h0);
    check("echo_end_sel", 16'(sel_s), 16'd0);
    wr(16'hBFFF, 8'h99);
    wr(16'hFE00, 8'h99);
    wr(16'h8010, 8'h99);
    rdchk("miss_no_write", 16'hC010, 8'h3C);
    rdchk("miss_no_write2", 16'hDDFF, 8'h61);
    for (int i = 0; i < 160; i++) wr(16'hC000 + 16'(i), pat(i));
    pulses = 0;
    for (int i = 0; i < 160; i++) begin
      q.push_back(pat(i));
      cyc(16'h0000, 8'h00, 1'b0, 1'b1, 16'hC000 + 16'(i));
    end
    check("dma_pulses", 16'(pulses), 16'd160);
    cyc(16'h0000, 8'h00, 1'b0, 1'b0, 16'h0);
    wr(16'hC200, 8'h22);
    q.push_back(pat(5));
    cyc(16'hC200, 8'h11, 1'b1, 1'b1, 16'hC005);
    check("dma_cycle_cpu_read", 16'(rd), 16'h00FF);
    rdchk("dma_cycle_write_dropped", 16'hC200, 8'h22);
    q.push_back(pat(1));
    cyc(16'hFF70, 8'h03, 1'b1, 1'b1, 16'hC001);
    q.push_back(pat(2));
    cyc(16'hFF70, 8'h00, 1'b0, 1'b1, 16'hC002);
    check("bankreg_during_dma", 16'(rd), 16'h00FB);
    wr(16'hD050, 8'h33);
    wr(16'hFF70, 8'h02);
    wr(16'hD050, 8'h22);
    q.push_back(8'h22);
    cyc(16'hFF70, 8'h03, 1'b1, 1'b1, 16'hD050);
    q.push_back(8'h33);
    cyc(16'h0000, 8'h00, 1'b0, 1'b1, 16'hD050);
    q.push_back(8'h33);
    cyc(16'h0000, 8'h00, 1'b0, 1'b1, 16'hF050);
    q.push_back(8'hFF);
    cyc(16'h0000, 8'h00, 1'b0, 1'b1, 16'h1234);
    abs_addr = 16'h0000; write_enable = 1'b0; dma_req = 1'b1; dma_addr = 16'hC000;
    @(negedge clk); #1 reset = 1'b1;
    #1;
    check("rst_mid_dma_valid", 16'(dma_valid), 16'd0);
    check("rst_mid_dma_data", 16'(dma_data), 16'h00FF);
    check("rst_mid_data_r", 16'(data_r), 16'h00FF);
    @(posedge clk); #1;
    check("rst_hold_dma_valid", 16'(dma_valid), 16'd0);
    dma_req = 1'b0; reset = 1'b0;
    rdchk("bank_after_reset", 16'hFF70, 8'hF9);
    q.push_back(pat(3));
    cyc(16'h0000, 8'h00, 1'b0, 1'b1, 16'hC003);
    cyc(16'h0000, 8'h00, 1'b0, 1'b0, 16'h0);
    check("queue_drained", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
